uart_rx_bridge: RTL and testbench
=================================

Name: uart_rx_bridge

Overview:
- Receives 8-bit UART characters from the FTDI USB module, which the laptop drives, and reassembles them into framed messages.
- Each frame is one header byte carrying a 2-bit mode, followed by MESSAGE_SIZE/8 payload bytes.
- Presents each complete message to the core as a single parallel word with a one-cycle valid strobe.
- Sits at the board UART input and feeds the control/decrypt path that consumes laptop commands.

Parameters:
- MESSAGE_SIZE, 512, payload bits per frame; must be a multiple of 8 and at least 8.
- CLKS_PER_BAUD, 868, clk_in cycles per UART bit (100 MHz / 115200); must be at least 4.
- TIMEOUT_BAUDS, 64, idle bit-periods allowed between bytes inside a frame before the frame is aborted.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-high
- uart_rx_in  input  1  raw serial line from FTDI; asynchronous; idles high
- message_out  output  MESSAGE_SIZE  last completed payload
- mode_out  output  2  mode from the last completed header: 00 MIXED, 01 RAW, 10 ENC
- message_valid_out  output  1  one-cycle pulse when message_out and mode_out update
- frame_error_out  output  1  one-cycle pulse when a frame is aborted or a header is rejected
- busy_out  output  1  high while a frame is partially received

Behaviour:
- Reset values:
  - message_out = 0, mode_out = 00.
  - message_valid_out, frame_error_out, busy_out = 0.
  - Both FSMs are in their idle states.
  - The synchronizer flops reset to 1.
- Synchronizer: uart_rx_in passes through 2 flops. All decoding uses the second flop (rx_s).
- Bit-level FSM: IDLE, START, DATA, STOP [, PARITY].
  - IDLE: rx_s == 0 moves to START and loads the baud counter.
  - START: after CLKS_PER_BAUD/2 cycles (integer division), resample rx_s.
    - If rx_s == 1, treat it as a glitch and return to IDLE with no error.
    - If rx_s == 0, go to DATA.
  - DATA: sample every CLKS_PER_BAUD cycles. Receive 8 bits, LSB first.
  - STOP: sample after a further CLKS_PER_BAUD cycles.
    - rx_s == 1 raises an internal byte_valid for one cycle.
    - rx_s == 0 is a framing error.
    - Both cases return to IDLE on the next cycle, so a start bit immediately following the stop-bit sample is caught.
- Frame FSM: WAIT_HDR, PAYLOAD.
  - WAIT_HDR: on byte_valid, accept the byte if bits[7:6] == 2'b10 and bits[1:0] != 2'b11.
    - On accept: latch the mode into a shadow register, clear the byte counter, go to PAYLOAD.
    - On reject: pulse frame_error_out and stay in WAIT_HDR.
  - PAYLOAD: byte k (0-based) goes into shadow[MESSAGE_SIZE-1-8k -: 8], so the first byte lands in the MSB.
    - On byte MESSAGE_SIZE/8-1: copy shadow to message_out and the shadow mode to mode_out, pulse message_valid_out, return to WAIT_HDR.
    - Latency: message_valid_out asserts exactly 1 cycle after the stop-bit sample of the final byte.
- busy_out is high exactly while the frame FSM is in PAYLOAD.
- Timeout:
  - In PAYLOAD, an idle counter starts when the bit FSM is in IDLE.
  - If it reaches TIMEOUT_BAUDS*CLKS_PER_BAUD cycles: abort to WAIT_HDR and pulse frame_error_out.
  - The counter clears whenever the bit FSM leaves IDLE.
- Framing error in any frame state: abort to WAIT_HDR and pulse frame_error_out.
  - The partial shadow is discarded; message_out is unchanged.
- No backpressure:
  - message_out holds until the next completed frame.
  - Consumers must capture it on message_valid_out.
  - A new frame overwrites the shadow only, never message_out mid-frame.
- Simultaneous events: error and completion are mutually exclusive per byte. A bad stop bit on the last byte gives an error, not valid.
- Reset mid-byte or mid-frame: all state clears immediately (asynchronous). The next falling edge after reset release starts a new character.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state between DATA and STOP samples one extra bit.
  - Even parity is required: XOR of the 8 data bits and the parity bit must be 0.
  - A mismatch is treated as a framing error: abort, frame_error_out pulse.
- Undefined:
  - No PARITY state; format is 8N1 and timing is unchanged from the base description.

Test Plan:
- Bench parameters: MESSAGE_SIZE=16, CLKS_PER_BAUD=8, TIMEOUT_BAUDS=4; macro undefined unless noted.
- Valid frame: send 0x81, 0xBE, 0xEF -> one message_valid_out pulse 1 cycle after the third stop sample; message_out=0xBEEF, mode_out=01; frame_error_out stays 0.
- Bad header: send 0x03, then a valid frame 0x82, 0x12, 0x34 -> frame_error_out pulses once after 0x03; then message_out=0x1234, mode_out=10.
- Glitch and framing error:
  - A 2-cycle low pulse on an idle line -> no activity.
  - Byte 0x80 followed by 0xAA sent with stop bit=0 -> frame_error_out pulse, busy_out drops, message_out unchanged.
- Timeout: send 0x80, 0x11, then stay idle for 40 cycles -> frame_error_out pulse at idle count 32; a new frame 0x80, 0x22, 0x33 yields 0x2233.
- Reset: assert rst_in mid-payload byte -> all outputs at reset values the same cycle; the next full frame decodes correctly.
- Parity (UART_RX_PARITY_EN): 0x81 with parity 0, then 0x01 with parity 0 (should be 1) -> frame_error_out pulse, no valid.

Source files
------------

// File: rtl/uart_rx_bridge_if.sv
// Serial input and framed-message outputs of the UART receive bridge.
interface uart_rx_bridge_if #(
    parameter int MESSAGE_SIZE = 512
);
    logic                    uart_rx_in;
    logic [MESSAGE_SIZE-1:0] message_out;
    logic [1:0]              mode_out;
    logic                    message_valid_out;
    logic                    frame_error_out;
    logic                    busy_out;

    modport master (
        output uart_rx_in,
        input  message_out, mode_out, message_valid_out,
        input  frame_error_out, busy_out
    );

    modport slave (
        input  uart_rx_in,
        output message_out, mode_out, message_valid_out,
        output frame_error_out, busy_out
    );
endinterface

// File: rtl/uart_rx_bridge.sv
// UART byte receiver plus header/payload framer; optional even parity
// bit when UART_RX_PARITY_EN is defined (8E1 instead of 8N1).
module uart_rx_bridge #(
    parameter int MESSAGE_SIZE  = 512,
    parameter int CLKS_PER_BAUD = 868,
    parameter int TIMEOUT_BAUDS = 64
) (
    input logic            clk_in,
    input logic            rst_in,
    uart_rx_bridge_if.slave bus
);
    localparam int NBYTES = MESSAGE_SIZE / 8;
    localparam int HALF   = CLKS_PER_BAUD / 2;
    localparam int CW     = $clog2(CLKS_PER_BAUD);
    localparam int TLIM   = TIMEOUT_BAUDS * CLKS_PER_BAUD;
    localparam int TW     = $clog2(TLIM + 1);
    localparam int BCW    = $clog2(NBYTES + 1);

    typedef enum logic [2:0] {
        B_IDLE, B_START, B_DATA, B_PARITY, B_STOP
    } bit_state_t;

    typedef enum logic {
        F_WAIT_HDR, F_PAYLOAD
    } frame_state_t;

`ifdef UART_RX_PARITY_EN
    localparam bit_state_t AFTER_DATA = B_PARITY;
`else
    localparam bit_state_t AFTER_DATA = B_STOP;
`endif

    logic              rx_q1, rx_s;
    bit_state_t        bstate;
    logic [CW-1:0]     baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        data;
    logic              byte_valid, byte_err;
    logic              par_err;

    frame_state_t          fstate;
    logic [MESSAGE_SIZE-1:0] shadow, next_shadow, message;
    logic [1:0]            shadow_mode, mode;
    logic [BCW-1:0]        byte_cnt;
    logic [TW-1:0]         idle_cnt;
    logic                  msg_valid, frame_err;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rx_q1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_q1 <= bus.uart_rx_in;
            rx_s  <= rx_q1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bstate     <= B_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            data       <= '0;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
            unique case (bstate)
                B_IDLE: begin
                    if (!rx_s) begin
                        bstate   <= B_START;
                        baud_cnt <= CW'(HALF - 1);
                    end
                end
                B_START: begin
                    if (baud_cnt == '0) begin
                        if (rx_s) begin
                            bstate <= B_IDLE;
                        end else begin
                            bstate   <= B_DATA;
                            baud_cnt <= CW'(CLKS_PER_BAUD - 1);
                            bit_idx  <= '0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                B_DATA: begin
                    if (baud_cnt == '0) begin
                        data     <= {rx_s, data[7:1]};
                        baud_cnt <= CW'(CLKS_PER_BAUD - 1);
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            bstate <= AFTER_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                B_PARITY: begin
                    if (baud_cnt == '0) begin
                        bstate   <= B_STOP;
                        baud_cnt <= CW'(CLKS_PER_BAUD - 1);
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
`endif
                B_STOP: begin
                    if (baud_cnt == '0) begin
                        bstate <= B_IDLE;
                        if (rx_s && !par_err)
                            byte_valid <= 1'b1;
                        else
                            byte_err <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: bstate <= B_IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits plus parity bit must XOR to zero.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            par_err <= 1'b0;
        else if (bstate == B_PARITY && baud_cnt == '0)
            par_err <= ^{data, rx_s};
    end
`else
    assign par_err = 1'b0;
`endif

    always_comb begin
        next_shadow = shadow;
        next_shadow[MESSAGE_SIZE-1-8*int'(byte_cnt) -: 8] = data;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            fstate      <= F_WAIT_HDR;
            shadow      <= '0;
            shadow_mode <= '0;
            byte_cnt    <= '0;
            idle_cnt    <= '0;
            message     <= '0;
            mode        <= '0;
            msg_valid   <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            msg_valid <= 1'b0;
            frame_err <= 1'b0;
            unique case (fstate)
                F_WAIT_HDR: begin
                    if (byte_valid) begin
                        if (data[7:6] == 2'b10 && data[1:0] != 2'b11) begin
                            fstate      <= F_PAYLOAD;
                            shadow_mode <= data[1:0];
                            byte_cnt    <= '0;
                            idle_cnt    <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else if (byte_err) begin
                        frame_err <= 1'b1;
                    end
                end
                F_PAYLOAD: begin
                    if (bstate != B_IDLE)
                        idle_cnt <= '0;
                    else
                        idle_cnt <= idle_cnt + 1'b1;
                    if (byte_err || (bstate == B_IDLE &&
                                     idle_cnt == TW'(TLIM - 1))) begin
                        fstate    <= F_WAIT_HDR;
                        frame_err <= 1'b1;
                    end else if (byte_valid) begin
                        shadow <= next_shadow;
                        if (byte_cnt == BCW'(NBYTES - 1)) begin
                            fstate    <= F_WAIT_HDR;
                            message   <= next_shadow;
                            mode      <= shadow_mode;
                            msg_valid <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                default: fstate <= F_WAIT_HDR;
            endcase
        end
    end

    assign bus.message_out       = message;
    assign bus.mode_out          = mode;
    assign bus.message_valid_out = msg_valid;
    assign bus.frame_error_out   = frame_err;
    assign bus.busy_out          = (fstate == F_PAYLOAD);
endmodule

// File: tb/tb_uart_rx_bridge.sv
// Scenario bench for uart_rx_bridge with a byte-stream reference model.
module tb_uart_rx_bridge;
    localparam int MS  = 16;
    localparam int CPB = 8;
    localparam int TOB = 4;
    // Edge of stop-bit sample, counted from the edge before the start bit:
    // 2 sync flops + detect edge, half a bit, then 9 full bits.
    localparam int STOP_LAT = 3 + CPB / 2 + 9 * CPB;
    localparam int EVT_LAT  = STOP_LAT + 1;
    localparam int TO_LAT   = STOP_LAT + TOB * CPB;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;

    uart_rx_bridge_if #(.MESSAGE_SIZE(MS)) bus ();

    uart_rx_bridge #(
        .MESSAGE_SIZE (MS),
        .CLKS_PER_BAUD(CPB),
        .TIMEOUT_BAUDS(TOB)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus   (bus)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    int            vcyc[$];
    logic [MS-1:0] vmsg[$];
    logic [1:0]    vmode[$];
    int            ecyc[$];

    always @(negedge clk_in) begin
        if (bus.message_valid_out) begin
            vcyc.push_back(cyc);
            vmsg.push_back(bus.message_out);
            vmode.push_back(bus.mode_out);
        end
        if (bus.frame_error_out)
            ecyc.push_back(cyc);
    end

    task automatic clear_obs();
        vcyc.delete();
        vmsg.delete();
        vmode.delete();
        ecyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit,
                             output int p0);
        @(negedge clk_in);
        p0 = cyc;
        bus.uart_rx_in = 1'b0;
        repeat (CPB) @(negedge clk_in);
        for (int i = 0; i < 8; i++) begin
            bus.uart_rx_in = b[i];
            repeat (CPB) @(negedge clk_in);
        end
        bus.uart_rx_in = stop_bit;
        repeat (CPB) @(negedge clk_in);
        bus.uart_rx_in = 1'b1;
    endtask

    task automatic test_reset();
        idle(3);
        checks++;
        if (bus.message_out !== '0) begin
            failures++;
            $display("FAIL reset_msg got=%h exp=0", bus.message_out);
        end
        checks++;
        if (bus.mode_out !== 2'b00) begin
            failures++;
            $display("FAIL reset_mode got=%b exp=00", bus.mode_out);
        end
        checks++;
        if (bus.message_valid_out !== 1'b0 || bus.frame_error_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_pulses got=%b%b exp=00",
                     bus.message_valid_out, bus.frame_error_out);
        end
        checks++;
        if (bus.busy_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", bus.busy_out);
        end
        rst_in = 1'b0;
        idle(4);
    endtask

    task automatic test_valid_frame();
        int p;
        clear_obs();
        send_byte(8'h81, 1'b1, p);
        checks++;
        if (bus.busy_out !== 1'b1) begin
            failures++;
            $display("FAIL valid_busy got=%b exp=1", bus.busy_out);
        end
        send_byte(8'hBE, 1'b1, p);
        send_byte(8'hEF, 1'b1, p);
        idle(10);
        checks++;
        if (vcyc.size() != 1) begin
            failures++;
            $display("FAIL valid_count got=%0d exp=1", vcyc.size());
        end else begin
            checks++;
            if (vcyc[0] != p + EVT_LAT) begin
                failures++;
                $display("FAIL valid_cycle got=%0d exp=%0d", vcyc[0], p + EVT_LAT);
            end
            checks++;
            if (vmsg[0] !== 16'hBEEF || vmode[0] !== 2'b01) begin
                failures++;
                $display("FAIL valid_data got=%h/%b exp=beef/01", vmsg[0], vmode[0]);
            end
        end
        checks++;
        if (ecyc.size() != 0 || bus.busy_out !== 1'b0) begin
            failures++;
            $display("FAIL valid_noerr got=%0d/%b exp=0/0", ecyc.size(), bus.busy_out);
        end
        checks++;
        if (bus.message_out !== 16'hBEEF) begin
            failures++;
            $display("FAIL valid_hold got=%h exp=beef", bus.message_out);
        end
    endtask

    task automatic test_bad_header();
        int p;
        clear_obs();
        send_byte(8'h03, 1'b1, p);
        idle(3);
        checks++;
        if (ecyc.size() != 1) begin
            failures++;
            $display("FAIL badhdr_count got=%0d exp=1", ecyc.size());
        end else begin
            checks++;
            if (ecyc[0] != p + EVT_LAT) begin
                failures++;
                $display("FAIL badhdr_cycle got=%0d exp=%0d", ecyc[0], p + EVT_LAT);
            end
        end
        checks++;
        if (bus.busy_out !== 1'b0) begin
            failures++;
            $display("FAIL badhdr_busy got=%b exp=0", bus.busy_out);
        end
        send_byte(8'h82, 1'b1, p);
        send_byte(8'h12, 1'b1, p);
        send_byte(8'h34, 1'b1, p);
        idle(10);
        checks++;
        if (vcyc.size() != 1 || ecyc.size() != 1) begin
            failures++;
            $display("FAIL badhdr_events got=%0d/%0d exp=1/1", vcyc.size(), ecyc.size());
        end
        checks++;
        if (bus.message_out !== 16'h1234 || bus.mode_out !== 2'b10) begin
            failures++;
            $display("FAIL badhdr_data got=%h/%b exp=1234/10",
                     bus.message_out, bus.mode_out);
        end
    endtask

    task automatic test_glitch();
        clear_obs();
        @(negedge clk_in);
        bus.uart_rx_in = 1'b0;
        idle(2);
        bus.uart_rx_in = 1'b1;
        idle(30);
        checks++;
        if (vcyc.size() != 0 || ecyc.size() != 0 || bus.busy_out !== 1'b0) begin
            failures++;
            $display("FAIL glitch got=%0d/%0d/%b exp=0/0/0",
                     vcyc.size(), ecyc.size(), bus.busy_out);
        end
    endtask

    task automatic test_framing_error();
        int p;
        clear_obs();
        send_byte(8'h80, 1'b1, p);
        send_byte(8'hAA, 1'b0, p);
        idle(20);
        checks++;
        if (ecyc.size() != 1 || vcyc.size() != 0) begin
            failures++;
            $display("FAIL ferr_events got=%0d/%0d exp=1/0", ecyc.size(), vcyc.size());
        end else begin
            checks++;
            if (ecyc[0] != p + EVT_LAT) begin
                failures++;
                $display("FAIL ferr_cycle got=%0d exp=%0d", ecyc[0], p + EVT_LAT);
            end
        end
        checks++;
        if (bus.busy_out !== 1'b0 || bus.message_out !== 16'h1234) begin
            failures++;
            $display("FAIL ferr_state got=%b/%h exp=0/1234", bus.busy_out, bus.message_out);
        end
    endtask

    task automatic test_timeout();
        int p;
        clear_obs();
        send_byte(8'h80, 1'b1, p);
        send_byte(8'h11, 1'b1, p);
        idle(40);
        checks++;
        if (ecyc.size() != 1) begin
            failures++;
            $display("FAIL timeout_count got=%0d exp=1", ecyc.size());
        end else begin
            checks++;
            if (ecyc[0] != p + TO_LAT) begin
                failures++;
                $display("FAIL timeout_cycle got=%0d exp=%0d", ecyc[0], p + TO_LAT);
            end
        end
        checks++;
        if (bus.busy_out !== 1'b0) begin
            failures++;
            $display("FAIL timeout_busy got=%b exp=0", bus.busy_out);
        end
        clear_obs();
        send_byte(8'h80, 1'b1, p);
        send_byte(8'h22, 1'b1, p);
        send_byte(8'h33, 1'b1, p);
        idle(10);
        checks++;
        if (vcyc.size() != 1 || ecyc.size() != 0) begin
            failures++;
            $display("FAIL timeout_next_events got=%0d/%0d exp=1/0",
                     vcyc.size(), ecyc.size());
        end
        checks++;
        if (bus.message_out !== 16'h2233 || bus.mode_out !== 2'b00) begin
            failures++;
            $display("FAIL timeout_next_data got=%h/%b exp=2233/00",
                     bus.message_out, bus.mode_out);
        end
    endtask

    task automatic test_reset_midframe();
        int p;
        send_byte(8'h81, 1'b1, p);
        @(negedge clk_in);
        bus.uart_rx_in = 1'b0;
        idle(20);
        rst_in = 1'b1;
        #1;
        checks++;
        if (bus.message_out !== '0 || bus.mode_out !== 2'b00) begin
            failures++;
            $display("FAIL rst_mid_data got=%h/%b exp=0/00", bus.message_out, bus.mode_out);
        end
        checks++;
        if (bus.busy_out !== 1'b0 || bus.message_valid_out !== 1'b0 ||
            bus.frame_error_out !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_flags got=%b%b%b exp=000", bus.busy_out,
                     bus.message_valid_out, bus.frame_error_out);
        end
        bus.uart_rx_in = 1'b1;
        idle(3);
        rst_in = 1'b0;
        idle(5);
        clear_obs();
        send_byte(8'h82, 1'b1, p);
        send_byte(8'h5A, 1'b1, p);
        send_byte(8'hC3, 1'b1, p);
        idle(10);
        checks++;
        if (vcyc.size() != 1 || ecyc.size() != 0) begin
            failures++;
            $display("FAIL rst_next_events got=%0d/%0d exp=1/0", vcyc.size(), ecyc.size());
        end
        checks++;
        if (bus.message_out !== 16'h5AC3 || bus.mode_out !== 2'b10) begin
            failures++;
            $display("FAIL rst_next_data got=%h/%b exp=5ac3/10",
                     bus.message_out, bus.mode_out);
        end
    endtask

    task automatic test_random_stream();
        logic [7:0]    stream[$];
        logic [7:0]    pay[$];
        int            xv_cyc[$];
        logic [MS-1:0] xv_msg[$];
        logic [1:0]    xv_mode[$];
        int            xe_cyc[$];
        logic          in_frame;
        logic [1:0]    cur_mode;
        logic [MS-1:0] last_msg;
        logic [1:0]    last_mode;
        logic [MS-1:0] m;
        logic [7:0]    b;
        int            p;
        for (int f = 0; f < 8; f++) begin
            if ($urandom_range(0, 3) == 0)
                b = 8'($urandom);
            else
                b = {2'b10, 4'($urandom), 2'($urandom_range(0, 2))};
            stream.push_back(b);
            for (int k = 0; k < MS / 8; k++)
                stream.push_back(8'($urandom));
        end
        in_frame  = 1'b0;
        cur_mode  = 2'b00;
        last_msg  = bus.message_out;
        last_mode = bus.mode_out;
        p = 0;
        clear_obs();
        foreach (stream[i]) begin
            send_byte(stream[i], 1'b1, p);
            b = stream[i];
            if (!in_frame) begin
                if (b[7:6] == 2'b10 && b[1:0] != 2'b11) begin
                    in_frame = 1'b1;
                    cur_mode = b[1:0];
                    pay.delete();
                end else begin
                    xe_cyc.push_back(p + EVT_LAT);
                end
            end else begin
                pay.push_back(b);
                if (pay.size() == MS / 8) begin
                    m = '0;
                    foreach (pay[j]) m = (m << 8) | MS'(pay[j]);
                    xv_cyc.push_back(p + EVT_LAT);
                    xv_msg.push_back(m);
                    xv_mode.push_back(cur_mode);
                    last_msg  = m;
                    last_mode = cur_mode;
                    in_frame  = 1'b0;
                end
            end
        end
        if (in_frame)
            xe_cyc.push_back(p + TO_LAT);
        idle(TOB * CPB + 20);
        checks++;
        if (vcyc.size() != xv_cyc.size()) begin
            failures++;
            $display("FAIL rnd_valid_count got=%0d exp=%0d", vcyc.size(), xv_cyc.size());
        end else begin
            foreach (xv_cyc[i]) begin
                checks++;
                if (vcyc[i] != xv_cyc[i] || vmsg[i] !== xv_msg[i] ||
                    vmode[i] !== xv_mode[i]) begin
                    failures++;
                    $display("FAIL rnd_valid[%0d] got=%0d/%h/%b exp=%0d/%h/%b", i,
                             vcyc[i], vmsg[i], vmode[i], xv_cyc[i], xv_msg[i], xv_mode[i]);
                end
            end
        end
        checks++;
        if (ecyc.size() != xe_cyc.size()) begin
            failures++;
            $display("FAIL rnd_err_count got=%0d exp=%0d", ecyc.size(), xe_cyc.size());
        end else begin
            foreach (xe_cyc[i]) begin
                checks++;
                if (ecyc[i] != xe_cyc[i]) begin
                    failures++;
                    $display("FAIL rnd_err[%0d] got=%0d exp=%0d", i, ecyc[i], xe_cyc[i]);
                end
            end
        end
        checks++;
        if (bus.message_out !== last_msg || bus.mode_out !== last_mode) begin
            failures++;
            $display("FAIL rnd_final got=%h/%b exp=%h/%b",
                     bus.message_out, bus.mode_out, last_msg, last_mode);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.uart_rx_in = 1'b1;
        test_reset();
        test_valid_frame();
        test_bad_header();
        test_glitch();
        test_framing_error();
        test_timeout();
        test_reset_midframe();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
